// File: rtl/uart_frame_tx.sv
// Periodic telemetry framer: snapshots NUM_CH channels and streams SYNC, LE payload, optional
// checksum and SYNC into a byte UART transmitter, interleaving echoed rx bytes at byte boundaries.
module uart_frame_tx #(
    parameter int          NUM_CH  = 4,
    parameter int          CH_W    = 32,
    parameter int          PERIOD  = 262144,
    parameter int          GAP_CYC = 255,
    parameter logic [7:0]  SYNC    = 8'h0A,
    parameter int          CHK_EN  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     frame_trig,
    input  logic [NUM_CH*CH_W-1:0]   ch_data,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic                     tx_busy,
    output logic                     tx_wr,
    output logic [7:0]               tx_data,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     frame_miss,
    output logic                     echo_ovf
);

    localparam int DW    = NUM_CH * CH_W;
    localparam int PAY_B = DW / 8;
    localparam int FB    = 2 + PAY_B + CHK_EN;
    localparam int IDX_W = $clog2(FB);
    localparam int TMR_W = $clog2(PERIOD);
    localparam int GAP_W = $clog2(GAP_CYC);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FB - 1);
    localparam logic [IDX_W-1:0] CHK_IDX  = IDX_W'(PAY_B + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_ECHO
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [TMR_W-1:0]   timer;
    logic               pending;
    logic [DW-1:0]      snap;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic [7:0]         chk;
    logic [GAP_W-1:0]   gap_cnt;
    logic               echo_full;
    logic [7:0]         echo_byte;
    logic               slot_open;
    logic               finish;
    logic               req;
    logic [7:0]         sel_byte;
    logic               is_pay;

    // Timer wrap and manual trigger in the same cycle collapse into a single request.
    assign req = frame_trig | (en & (timer == TMR_LAST));

    assign slot_open = (state == S_IDLE) || ((state == S_WAIT) && (gap_cnt == GAP_LAST));

    always_comb begin
        next_state = state;
        idx_nxt    = idx;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!tx_busy) begin
                    if (echo_full) begin
                        next_state = S_ECHO;
                    end else if (pending) begin
                        next_state = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                idx_nxt    = '0;
                next_state = S_SEND;
            end
            S_SEND: begin
                next_state = S_WAIT;
            end
            S_WAIT: begin
                // busy doubles as the "frame in flight" flag for echoes issued from IDLE.
                if (slot_open && !tx_busy) begin
                    if (echo_full) begin
                        next_state = S_ECHO;
                    end else if (!busy) begin
                        next_state = S_IDLE;
                    end else if (idx == LAST_IDX) begin
                        next_state = S_IDLE;
                        finish     = 1'b1;
                    end else begin
                        idx_nxt    = idx + 1'b1;
                        next_state = S_SEND;
                    end
                end
            end
            S_ECHO: begin
                next_state = S_WAIT;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Byte for the index about to be sent; chk is complete by the time the checksum slot comes up.
    always_comb begin
        sel_byte = SYNC;
        is_pay   = 1'b0;
        for (int k = 0; k < PAY_B; k++) begin
            if (idx_nxt == IDX_W'(k + 1)) begin
                sel_byte = snap[k*8 +: 8];
                is_pay   = 1'b1;
            end
        end
        if ((CHK_EN != 0) && (idx_nxt == CHK_IDX)) begin
            sel_byte = chk;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= next_state;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer      <= '0;
            pending    <= 1'b0;
            frame_miss <= 1'b0;
        end else begin
            if (!en || (timer == TMR_LAST)) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            // A request landing in LOAD sees the pending slot already being consumed.
            if (req) begin
                if (pending && (state != S_LOAD)) begin
                    frame_miss <= 1'b1;
                end else begin
                    pending <= 1'b1;
                end
            end else if (state == S_LOAD) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap    <= '0;
            chk     <= '0;
            gap_cnt <= '0;
        end else begin
            if (state == S_LOAD) begin
                snap <= ch_data;
                chk  <= '0;
            end else if ((next_state == S_SEND) && is_pay) begin
                chk <= chk + sel_byte;
            end
            if ((next_state == S_SEND) || (next_state == S_ECHO)) begin
                gap_cnt <= '0;
            end else if (gap_cnt != GAP_LAST) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    // Echo buffer is released at the end of ECHO, so an rx byte in that same cycle is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_full <= 1'b0;
            echo_byte <= '0;
            echo_ovf  <= 1'b0;
        end else if (state == S_ECHO) begin
            echo_full <= rx_valid;
            if (rx_valid) begin
                echo_byte <= rx_data;
            end
        end else if (rx_valid) begin
            if (echo_full) begin
                echo_ovf <= 1'b1;
            end else begin
                echo_full <= 1'b1;
                echo_byte <= rx_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr      <= 1'b0;
            tx_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx_wr      <= (next_state == S_SEND) || (next_state == S_ECHO);
            frame_done <= finish;
            if (next_state == S_SEND) begin
                tx_data <= sel_byte;
            end else if (next_state == S_ECHO) begin
                tx_data <= echo_byte;
            end
            if (state == S_LOAD) begin
                busy <= 1'b1;
            end else if (finish) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: byte scoreboard fed by expected frames/echoes, scenario tasks check timing.
module tb_uart_frame_tx;

    localparam int         NUM_CH  = 2;
    localparam int         CH_W    = 16;
    localparam int         PERIOD  = 1000;
    localparam int         GAP_CYC = 20;
    localparam logic [7:0] SYNC    = 8'h0A;
    localparam int         CHK_EN  = 1;
    localparam int         DW      = NUM_CH * CH_W;
    localparam int         PAY_B   = DW / 8;
    localparam int         FB      = 2 + PAY_B + CHK_EN;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          frame_trig;
    logic [DW-1:0] ch_data;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          tx_busy;
    logic          tx_wr;
    logic [7:0]    tx_data;
    logic          busy;
    logic          frame_done;
    logic          frame_miss;
    logic          echo_ovf;

    logic [7:0] exp_q[$];
    int         wr_cyc_q[$];
    int         rise_q[$];
    int         done_cyc_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         wr_cnt = 0;
    int         done_cnt = 0;
    logic       busy_prev = 1'b0;
    logic [7:0] exp_b;

    uart_frame_tx #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .PERIOD(PERIOD),
        .GAP_CYC(GAP_CYC), .SYNC(SYNC), .CHK_EN(CHK_EN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .frame_trig(frame_trig),
        .ch_data(ch_data), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_wr(tx_wr), .tx_data(tx_data), .busy(busy),
        .frame_done(frame_done), .frame_miss(frame_miss), .echo_ovf(echo_ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_wr) begin
                wr_cnt++;
                wr_cyc_q.push_back(cyc);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL tx_byte: got %h, required no byte at cycle %0d", tx_data, cyc);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (tx_data !== exp_b) begin
                        n_bad++;
                        $display("FAIL tx_byte: got %h, required %h at cycle %0d", tx_data, exp_b, cyc);
                    end
                end
                n_cmp++;
                if (tx_busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wr_while_busy: tx_busy %b, required 0 at cycle %0d", tx_busy, cyc);
                end
            end
            if (frame_done === 1'b1) begin
                done_cnt++;
                done_cyc_q.push_back(cyc);
            end
            if (busy === 1'b1 && !busy_prev) rise_q.push_back(cyc);
            busy_prev = (busy === 1'b1);
        end else begin
            busy_prev = 1'b0;
        end
    end

    // reference model of the frame byte stream
    function automatic logic [7:0] model_byte(input logic [DW-1:0] d, input int i);
        logic [7:0] s;
        s = 8'h00;
        for (int k = 0; k < PAY_B; k++) s = s + d[k*8 +: 8];
        if (i == 0) return SYNC;
        if (i <= PAY_B) return d[(i-1)*8 +: 8];
        if (CHK_EN != 0 && i == PAY_B + 1) return s;
        return SYNC;
    endfunction

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [DW-1:0] d, input int first, input int last);
        for (int i = first; i <= last; i++) exp_q.push_back(model_byte(d, i));
    endtask

    task automatic pulse_trig();
        frame_trig = 1'b1;
        tick(1);
        frame_trig = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic wait_wr(input int target, input int budget, input string what);
        int i = 0;
        while (wr_cnt < target && i < budget) begin
            tick(1);
            i++;
        end
        if (wr_cnt < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout with %0d writes, required %0d", what, wr_cnt, target);
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string what);
        int i = 0;
        while (done_cnt < target && i < budget) begin
            tick(1);
            i++;
        end
        if (done_cnt < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout with %0d frame_done, required %0d", what, done_cnt, target);
        end
    endtask

    // scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        n_cmp += 6;
        if (tx_wr !== 1'b0)        begin n_bad++; $display("FAIL rst_tx_wr: got %b, required 0", tx_wr); end
        if (tx_data !== 8'h00)     begin n_bad++; $display("FAIL rst_tx_data: got %h, required 00", tx_data); end
        if (busy !== 1'b0)         begin n_bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (frame_done !== 1'b0)   begin n_bad++; $display("FAIL rst_frame_done: got %b, required 0", frame_done); end
        if (frame_miss !== 1'b0)   begin n_bad++; $display("FAIL rst_frame_miss: got %b, required 0", frame_miss); end
        if (echo_ovf !== 1'b0)     begin n_bad++; $display("FAIL rst_echo_ovf: got %b, required 0", echo_ovf); end
        rst_n = 1'b1;
        tick(5);
        n_cmp++;
        if (tx_wr !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: tx_wr %b busy %b, required 0 0", tx_wr, busy);
        end
    endtask

    task automatic test_single_frame();
        logic [DW-1:0] d;
        int w0, d0, t_trig, busy_low;
        d = {16'hABCD, 16'h1234};
        ch_data = d;
        wr_cyc_q.delete();
        w0 = wr_cnt;
        d0 = done_cnt;
        busy_low = 0;
        push_frame(d, 0, FB - 1);
        t_trig = cyc;
        pulse_trig();
        for (int i = 0; i < 400 && done_cnt < d0 + 1; i++) begin
            if (wr_cnt > w0 && frame_done !== 1'b1 && busy !== 1'b1) busy_low++;
            tick(1);
        end
        tick(5);
        n_cmp++;
        if (done_cnt != d0 + 1) begin n_bad++; $display("FAIL single_done_count: got %0d, required %0d", done_cnt - d0, 1); end
        n_cmp++;
        if (wr_cnt - w0 != FB) begin n_bad++; $display("FAIL single_byte_count: got %0d, required %0d", wr_cnt - w0, FB); end
        n_cmp++;
        if (busy_low != 0) begin n_bad++; $display("FAIL single_busy: low for %0d cycles, required 0", busy_low); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL single_leftover: %0d bytes, required 0", exp_q.size()); end
        if (wr_cyc_q.size() == FB) begin
            n_cmp++;
            if (wr_cyc_q[0] - t_trig != 3) begin
                n_bad++;
                $display("FAIL single_latency: got %0d, required 3", wr_cyc_q[0] - t_trig);
            end
            for (int i = 1; i < FB; i++) begin
                n_cmp++;
                if (wr_cyc_q[i] - wr_cyc_q[i-1] != GAP_CYC) begin
                    n_bad++;
                    $display("FAIL single_spacing: byte %0d gap %0d, required %0d", i, wr_cyc_q[i] - wr_cyc_q[i-1], GAP_CYC);
                end
            end
            n_cmp++;
            if (done_cyc_q[done_cyc_q.size()-1] - wr_cyc_q[FB-1] != GAP_CYC) begin
                n_bad++;
                $display("FAIL single_done_time: got %0d, required %0d", done_cyc_q[done_cyc_q.size()-1] - wr_cyc_q[FB-1], GAP_CYC);
            end
        end
    endtask

    task automatic test_echo_idle();
        int w0, d0, r;
        wr_cyc_q.delete();
        w0 = wr_cnt;
        d0 = done_cnt;
        exp_q.push_back(8'h77);
        r = cyc;
        send_rx(8'h77);
        wait_wr(w0 + 1, 50, "echo_idle_wait");
        n_cmp++;
        if (wr_cyc_q.size() < 1 || wr_cyc_q[0] - r != 2) begin
            n_bad++;
            $display("FAIL echo_idle_latency: got %0d, required 2", (wr_cyc_q.size() > 0) ? wr_cyc_q[0] - r : -1);
        end
        tick(GAP_CYC + 5);
        n_cmp++;
        if (busy !== 1'b0 || done_cnt != d0) begin
            n_bad++;
            $display("FAIL echo_idle_frame: busy %b done %0d, required 0 0", busy, done_cnt - d0);
        end
    endtask

    task automatic test_echo_mid_frame();
        logic [DW-1:0] d;
        int w0, d0;
        d = DW'($urandom());
        ch_data = d;
        wr_cyc_q.delete();
        w0 = wr_cnt;
        d0 = done_cnt;
        push_frame(d, 0, 3);
        pulse_trig();
        tick(5);
        ch_data = ~d;
        wait_wr(w0 + 4, 300, "echo_mid_wait");
        exp_q.push_back(8'h55);
        push_frame(d, 4, FB - 1);
        send_rx(8'h55);
        wait_done(d0 + 1, 400, "echo_mid_done");
        tick(3);
        n_cmp++;
        if (wr_cnt - w0 != FB + 1) begin n_bad++; $display("FAIL echo_mid_count: got %0d, required %0d", wr_cnt - w0, FB + 1); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL echo_mid_leftover: %0d bytes, required 0", exp_q.size()); end
        if (wr_cyc_q.size() >= 6) begin
            n_cmp++;
            if (wr_cyc_q[4] - wr_cyc_q[3] != GAP_CYC || wr_cyc_q[5] - wr_cyc_q[4] != GAP_CYC) begin
                n_bad++;
                $display("FAIL echo_mid_spacing: gaps %0d %0d, required %0d", wr_cyc_q[4] - wr_cyc_q[3], wr_cyc_q[5] - wr_cyc_q[4], GAP_CYC);
            end
        end
    endtask

    task automatic test_echo_overflow();
        logic [DW-1:0] d;
        int w0, d0;
        n_cmp++;
        if (echo_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_before: got %b, required 0", echo_ovf); end
        d = DW'($urandom());
        ch_data = d;
        w0 = wr_cnt;
        d0 = done_cnt;
        push_frame(d, 0, 1);
        pulse_trig();
        wait_wr(w0 + 2, 300, "ovf_wait");
        exp_q.push_back(8'h11);
        push_frame(d, 2, FB - 1);
        send_rx(8'h11);
        tick(2);
        send_rx(8'h22);
        wait_done(d0 + 1, 400, "ovf_done");
        tick(3);
        n_cmp++;
        if (echo_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b, required 1", echo_ovf); end
        n_cmp++;
        if (wr_cnt - w0 != FB + 1) begin n_bad++; $display("FAIL ovf_count: got %0d, required %0d", wr_cnt - w0, FB + 1); end
    endtask

    task automatic test_tx_busy_stall();
        logic [DW-1:0] d;
        int w0, w1, d0, f;
        d = DW'($urandom());
        ch_data = d;
        wr_cyc_q.delete();
        w0 = wr_cnt;
        d0 = done_cnt;
        push_frame(d, 0, FB - 1);
        pulse_trig();
        wait_wr(w0 + 3, 300, "stall_wait");
        tx_busy = 1'b1;
        w1 = wr_cnt;
        tick(500);
        n_cmp++;
        if (wr_cnt != w1) begin n_bad++; $display("FAIL stall_quiet: %0d writes, required 0", wr_cnt - w1); end
        f = cyc;
        tx_busy = 1'b0;
        wait_wr(w1 + 1, 50, "stall_release");
        n_cmp++;
        if (wr_cyc_q.size() < 4 || wr_cyc_q[3] - f != 1) begin
            n_bad++;
            $display("FAIL stall_resume: got %0d, required 1", (wr_cyc_q.size() > 3) ? wr_cyc_q[3] - f : -1);
        end
        wait_done(d0 + 1, 400, "stall_done");
        tick(3);
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL stall_leftover: %0d bytes, required 0", exp_q.size()); end
    endtask

    task automatic test_periodic();
        logic [DW-1:0] d;
        int d0, i;
        n_cmp++;
        if (frame_miss !== 1'b0) begin n_bad++; $display("FAIL miss_before: got %b, required 0", frame_miss); end
        d = DW'($urandom());
        ch_data = d;
        rise_q.delete();
        done_cyc_q.delete();
        d0 = done_cnt;
        for (int k = 0; k < 3; k++) push_frame(d, 0, FB - 1);
        en = 1'b1;
        i = 0;
        while (rise_q.size() < 1 && i < 1200) begin tick(1); i++; end
        tick(30);
        pulse_trig();
        tick(10);
        pulse_trig();
        i = 0;
        while (rise_q.size() < 3 && i < 1200) begin tick(1); i++; end
        en = 1'b0;
        wait_done(d0 + 3, 400, "periodic_done");
        tick(3);
        n_cmp++;
        if (frame_miss !== 1'b1) begin n_bad++; $display("FAIL periodic_miss: got %b, required 1", frame_miss); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL periodic_leftover: %0d bytes, required 0", exp_q.size()); end
        n_cmp++;
        if (rise_q.size() != 3) begin
            n_bad++;
            $display("FAIL periodic_frames: got %0d, required 3", rise_q.size());
        end else begin
            n_cmp++;
            if (rise_q[2] - rise_q[0] != PERIOD) begin
                n_bad++;
                $display("FAIL periodic_interval: got %0d, required %0d", rise_q[2] - rise_q[0], PERIOD);
            end
            n_cmp++;
            if (done_cyc_q.size() < 1 || rise_q[1] - done_cyc_q[0] != 2) begin
                n_bad++;
                $display("FAIL periodic_followon: got %0d, required 2", (done_cyc_q.size() > 0) ? rise_q[1] - done_cyc_q[0] : -1);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [DW-1:0] d;
        int w0, d0;
        d = DW'($urandom());
        ch_data = d;
        w0 = wr_cnt;
        push_frame(d, 0, FB - 1);
        pulse_trig();
        wait_wr(w0 + 2, 300, "rst_mid_wait");
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_cmp += 6;
        if (tx_wr !== 1'b0)      begin n_bad++; $display("FAIL mid_rst_tx_wr: got %b, required 0", tx_wr); end
        if (tx_data !== 8'h00)   begin n_bad++; $display("FAIL mid_rst_tx_data: got %h, required 00", tx_data); end
        if (busy !== 1'b0)       begin n_bad++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
        if (frame_done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done: got %b, required 0", frame_done); end
        if (frame_miss !== 1'b0) begin n_bad++; $display("FAIL mid_rst_miss: got %b, required 0", frame_miss); end
        if (echo_ovf !== 1'b0)   begin n_bad++; $display("FAIL mid_rst_ovf: got %b, required 0", echo_ovf); end
        tick(4);
        rst_n = 1'b1;
        tick(3);
        d = DW'($urandom());
        ch_data = d;
        w0 = wr_cnt;
        d0 = done_cnt;
        push_frame(d, 0, FB - 1);
        pulse_trig();
        wait_done(d0 + 1, 400, "rst_mid_done");
        tick(3);
        n_cmp++;
        if (wr_cnt - w0 != FB) begin n_bad++; $display("FAIL rst_mid_count: got %0d, required %0d", wr_cnt - w0, FB); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("FAIL rst_mid_leftover: %0d bytes, required 0", exp_q.size()); end
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        frame_trig = 1'b0;
        ch_data    = '0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        tx_busy    = 1'b0;
        test_reset();
        test_single_frame();
        test_echo_idle();
        test_echo_mid_frame();
        test_echo_overflow();
        test_tx_busy_stall();
        test_periodic();
        test_reset_mid_frame();
        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
